// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: FSM states, ALU op codes, response flags.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_AND   = 2'b01;
  localparam logic [1:0] ALU_XOR   = 2'b10;
  localparam logic [1:0] ALU_SHIFT = 2'b11;

  // Field order matches the o_rspFlags bit order {negative, nZero, overflow, carry}.
  typedef struct packed {
    logic negative;
    logic nZero;
    logic overflow;
    logic carry;
  } flags_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin arbiter: searches req upward from the pointer
// (wrapping) and returns a one-hot grant plus the encoded winner index.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o
);

  // Priority search starting at the pointer; first pending request wins.
  always_comb begin
    logic found;
    int   cand;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int off = 0; off < N; off++) begin
      cand = (int'(ptr_i) + off) % N;
      if (!found && req_i[IDX_W'(cand)]) begin
        found                   = 1'b1;
        grant_o[IDX_W'(cand)]   = 1'b1;
        idx_o                   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 8-bit ALU between N_REQ requesters. A round-robin winner is
// latched, its operands are written into the ALU Y register (LOAD), the
// result is read back over the bus (READ) and returned with flags (RESP).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int LOAD_CYCLES = 1,
  parameter int READ_CYCLES = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [N_REQ-1:0]   i_reqValid,
  output logic [N_REQ-1:0]   o_reqReady,
  input  logic [N_REQ*8-1:0] i_reqA,
  input  logic [N_REQ*8-1:0] i_reqB,
  input  logic [N_REQ*2-1:0] i_reqOp,
  input  logic [N_REQ-1:0]   i_reqSub,
  output logic [N_REQ-1:0]   o_rspValid,
  input  logic [N_REQ-1:0]   i_rspReady,
  output logic [7:0]         o_rspData,
  output logic [3:0]         o_rspFlags,
  output logic [7:0]         o_aluA,
  output logic [7:0]         o_aluBus,
  output logic               o_aluBusOE,
  input  logic [7:0]         i_aluBus,
  output logic               o_ctrlAluNOE,
  output logic [1:0]         o_ctrlAluOp,
  output logic               o_ctrlAluSub,
  output logic               o_ctrlAluYNWE,
  input  logic               i_flagNegative,
  input  logic               i_flagNZero,
  input  logic               i_flagOverflow,
  input  logic               i_flagCarry
);

  localparam int PTR_W   = $clog2(N_REQ);
  localparam int MAX_CYC = (LOAD_CYCLES > READ_CYCLES) ? LOAD_CYCLES : READ_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(READ_CYCLES - 1);
  localparam logic [PTR_W-1:0] IDX_MAX   = PTR_W'(N_REQ - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx_q, idx_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             sub_q, sub_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  flags_t           rsp_flags_q, rsp_flags_d;

  logic [N_REQ-1:0] gnt;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_any;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (PTR_W)
  ) u_rr (
    .req_i   (i_reqValid),
    .ptr_i   (ptr_q),
    .grant_o (gnt),
    .idx_o   (gnt_idx)
  );

  assign gnt_any = |gnt;

  // Next-state, request latch, phase counter, pointer and response capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    sub_d       = sub_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          idx_d   = gnt_idx;
          a_d     = i_reqA[{gnt_idx, 3'b000} +: 8];
          b_d     = i_reqB[{gnt_idx, 3'b000} +: 8];
          op_d    = i_reqOp[{gnt_idx, 1'b0} +: 2];
          sub_d   = i_reqSub[gnt_idx];
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = READ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READ: begin
        if (cnt_q == READ_LAST) begin
          rsp_data_d           = i_aluBus;
          rsp_flags_d.negative = i_flagNegative;
          rsp_flags_d.nZero    = i_flagNZero;
          rsp_flags_d.overflow = i_flagOverflow;
          rsp_flags_d.carry    = i_flagCarry;
          cnt_d                = '0;
          state_d              = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (i_rspReady[idx_q]) begin
          ptr_d   = (idx_q == IDX_MAX) ? '0 : idx_q + PTR_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU control decode from state; bus driver and ALU output are never on together.
  always_comb begin
    o_reqReady    = '0;
    o_rspValid    = '0;
    o_aluA        = '0;
    o_aluBus      = '0;
    o_aluBusOE    = 1'b0;
    o_ctrlAluNOE  = 1'b1;
    o_ctrlAluYNWE = 1'b1;
    o_ctrlAluOp   = ALU_ADD;
    o_ctrlAluSub  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!i_reset) o_reqReady = gnt;
      end
      LOAD: begin
        o_aluA        = a_q;
        o_aluBus      = b_q;
        o_aluBusOE    = 1'b1;
        o_ctrlAluYNWE = 1'b0;
        o_ctrlAluOp   = op_q;
        o_ctrlAluSub  = sub_q;
      end
      READ: begin
        o_aluA       = a_q;
        o_ctrlAluNOE = 1'b0;
        o_ctrlAluOp  = op_q;
        o_ctrlAluSub = sub_q;
      end
      RESP: begin
        o_rspValid[idx_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_rspData  = rsp_data_q;
  assign o_rspFlags = rsp_flags_q;

  // Control and response registers reset; operand latch only loads on accept.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      idx_q       <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
    end
    a_q   <= a_d;
    b_q   <= b_d;
    op_q  <= op_d;
    sub_q <= sub_d;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 8-bit ALU on the bus side.
module tb_alu_arbiter;

  localparam int N = 3;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
  logic [N*8-1:0] req_a, req_b;
  logic [N*2-1:0] req_op;
  logic [7:0]     rsp_data, alu_a, alu_bus_o, alu_bus_i;
  logic [3:0]     rsp_flags;
  logic           bus_oe, noe, ynwe, alu_sub;
  logic [1:0]     alu_op;
  logic           f_n, f_nz, f_v, f_c;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.N_REQ(N), .LOAD_CYCLES(1), .READ_CYCLES(1)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_reqValid(req_valid), .o_reqReady(req_ready),
    .i_reqA(req_a), .i_reqB(req_b), .i_reqOp(req_op), .i_reqSub(req_sub),
    .o_rspValid(rsp_valid), .i_rspReady(rsp_ready),
    .o_rspData(rsp_data), .o_rspFlags(rsp_flags),
    .o_aluA(alu_a), .o_aluBus(alu_bus_o), .o_aluBusOE(bus_oe), .i_aluBus(alu_bus_i),
    .o_ctrlAluNOE(noe), .o_ctrlAluOp(alu_op), .o_ctrlAluSub(alu_sub), .o_ctrlAluYNWE(ynwe),
    .i_flagNegative(f_n), .i_flagNZero(f_nz), .i_flagOverflow(f_v), .i_flagCarry(f_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: {flags[3:0], result[7:0]}.
  function automatic logic [11:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op, input logic sub);
    logic [7:0] bb, r;
    logic [8:0] s;
    logic       c, v;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {8'd0, sub};
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      2'b00: begin r = s[7:0]; c = s[8]; v = (a[7] == bb[7]) && (r[7] != a[7]); end
      2'b01: r = a & b;
      2'b10: r = a ^ b;
      default: r = sub ? (a << b[2:0]) : (a >> b[2:0]);
    endcase
    return {r[7], |r, v, c, r};
  endfunction

  logic [7:0] y_q;
  logic [3:0] yf_q;
  always @(posedge clk)
    if (!ynwe) {yf_q, y_q} <= alu_calc(alu_a, bus_oe ? alu_bus_o : 8'h00, alu_op, alu_sub);
  assign alu_bus_i = noe ? 8'h00 : y_q;
  assign {f_n, f_nz, f_v, f_c} = noe ? 4'h0 : yf_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic sub);
    req_a[r*8 +: 8]  = a;
    req_b[r*8 +: 8]  = b;
    req_op[r*2 +: 2] = op;
    req_sub[r]       = sub;
  endtask

  // Issues one request from an idle DUT and returns what the response looked like.
  task automatic run_txn(input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic sub, output int lat,
                         output logic [7:0] d, output logic [3:0] f, output logic [N-1:0] rv);
    set_req(r, a, b, op, sub);
    req_valid    = '0;
    req_valid[r] = 1'b1;
    step();
    req_valid = '0;
    lat = 1;
    while (rsp_valid == '0 && lat < 40) begin
      step();
      lat++;
    end
    d  = rsp_data;
    f  = rsp_flags;
    rv = rsp_valid;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = '1;
    req_a = '0; req_b = '0; req_op = '0; req_sub = '0;
    step();
    step();
    n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got %b want 000", req_ready); end
    n_checks++; if (rsp_valid !== 3'b000) begin n_fail++; $display("FAIL reset_rspvalid got %b want 000", rsp_valid); end
    n_checks++; if ({rsp_data, rsp_flags} !== 12'h000) begin n_fail++; $display("FAIL reset_rsp got %h/%h want 00/0", rsp_data, rsp_flags); end
    n_checks++; if ({alu_a, alu_bus_o} !== 16'h0000) begin n_fail++; $display("FAIL reset_operands got %h/%h want 00/00", alu_a, alu_bus_o); end
    n_checks++; if ({bus_oe, noe, ynwe, alu_op, alu_sub} !== 6'b011000) begin n_fail++; $display("FAIL reset_ctrl got %b want 011000", {bus_oe, noe, ynwe, alu_op, alu_sub}); end
    rst = 1'b0;
    step();
    step();
    n_checks++; if ({req_ready, rsp_valid, bus_oe, noe, ynwe} !== 9'b000000011) begin n_fail++; $display("FAIL idle_norequest got %b want 000000011", {req_ready, rsp_valid, bus_oe, noe, ynwe}); end
  endtask

  task automatic test_add();
    int lat; logic [7:0] d; logic [3:0] f; logic [N-1:0] rv;
    run_txn(0, 8'h14, 8'h16, 2'b00, 1'b0, lat, d, f, rv);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency got %0d want 3", lat); end
    n_checks++; if (rv !== 3'b001) begin n_fail++; $display("FAIL add_rspvalid got %b want 001", rv); end
    n_checks++; if (d !== 8'h2A) begin n_fail++; $display("FAIL add_data got %h want 2a", d); end
    n_checks++; if (f !== 4'b0100) begin n_fail++; $display("FAIL add_flags got %b want 0100", f); end
    run_txn(0, 8'hC8, 8'h38, 2'b00, 1'b0, lat, d, f, rv);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL add_carry_data got %h want 00", d); end
    n_checks++; if (f !== 4'b0001) begin n_fail++; $display("FAIL add_carry_flags got %b want 0001", f); end
    run_txn(0, 8'h48, 8'h4F, 2'b00, 1'b0, lat, d, f, rv);
    n_checks++; if (d !== 8'h97) begin n_fail++; $display("FAIL add_ovf_data got %h want 97", d); end
    n_checks++; if (f !== 4'b1110) begin n_fail++; $display("FAIL add_ovf_flags got %b want 1110", f); end
  endtask

  task automatic test_round_robin();
    int w;
    do_reset();
    set_req(0, 8'h2A, 8'h0F, 2'b01, 1'b0);
    set_req(1, 8'h2A, 8'h0F, 2'b10, 1'b0);
    req_valid = 3'b011;
    #1;
    n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL rr_first_grant got %b want 001", req_ready); end
    step();
    req_valid[0] = 1'b0;
    w = 0; while (rsp_valid == '0 && w < 40) begin step(); w++; end
    n_checks++; if ({rsp_valid, rsp_data} !== {3'b001, 8'h0A}) begin n_fail++; $display("FAIL rr_req0 got %b/%h want 001/0a", rsp_valid, rsp_data); end
    step();
    n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL rr_second_grant got %b want 010", req_ready); end
    step();
    req_valid[1] = 1'b0;
    w = 0; while (rsp_valid == '0 && w < 40) begin step(); w++; end
    n_checks++; if ({rsp_valid, rsp_data} !== {3'b010, 8'h25}) begin n_fail++; $display("FAIL rr_req1 got %b/%h want 010/25", rsp_valid, rsp_data); end
    step();
    set_req(1, 8'h01, 8'h01, 2'b00, 1'b0);
    set_req(2, 8'hFF, 8'h0F, 2'b10, 1'b0);
    req_valid = 3'b110;
    #1;
    n_checks++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL rr_wrap_grant got %b want 100", req_ready); end
    step();
    req_valid[2] = 1'b0;
    w = 0; while (rsp_valid == '0 && w < 40) begin step(); w++; end
    n_checks++; if ({rsp_valid, rsp_data} !== {3'b100, 8'hF0}) begin n_fail++; $display("FAIL rr_req2 got %b/%h want 100/f0", rsp_valid, rsp_data); end
    step();
    n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL rr_after_wrap got %b want 010", req_ready); end
    step();
    req_valid[1] = 1'b0;
    w = 0; while (rsp_valid == '0 && w < 40) begin step(); w++; end
    n_checks++; if ({rsp_valid, rsp_data} !== {3'b010, 8'h02}) begin n_fail++; $display("FAIL rr_req1_add got %b/%h want 010/02", rsp_valid, rsp_data); end
    step();
  endtask

  task automatic test_shift_sub();
    int lat; logic [7:0] d; logic [3:0] f; logic [N-1:0] rv;
    run_txn(2, 8'h2A, 8'h03, 2'b11, 1'b1, lat, d, f, rv);
    n_checks++; if (d !== 8'h50) begin n_fail++; $display("FAIL shift_left got %h want 50", d); end
    run_txn(2, 8'h2A, 8'h01, 2'b11, 1'b0, lat, d, f, rv);
    n_checks++; if (d !== 8'h15) begin n_fail++; $display("FAIL shift_right got %h want 15", d); end
    run_txn(1, 8'h2A, 8'h0F, 2'b00, 1'b1, lat, d, f, rv);
    n_checks++; if ({d, f} !== {8'h1B, 4'b0101}) begin n_fail++; $display("FAIL sub got %h/%b want 1b/0101", d, f); end
    n_checks++; if (rv !== 3'b010) begin n_fail++; $display("FAIL sub_rspvalid got %b want 010", rv); end
  endtask

  task automatic test_backpressure();
    int w;
    do_reset();
    rsp_ready = '0;
    set_req(0, 8'h14, 8'h16, 2'b00, 1'b0);
    req_valid = 3'b001;
    step();
    req_valid = '0;
    w = 0;
    while (rsp_valid == '0 && w < 40) begin
      n_checks++; if ((bus_oe & ~noe) !== 1'b0) begin n_fail++; $display("FAIL contention_pre got oe=%b noe=%b want no overlap", bus_oe, noe); end
      step(); w++;
    end
    set_req(1, 8'h01, 8'h02, 2'b00, 1'b0);
    req_valid = 3'b010;
    rsp_ready = 3'b110;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++; if ({rsp_valid, rsp_data, rsp_flags} !== {3'b001, 8'h2A, 4'b0100}) begin n_fail++; $display("FAIL bp_hold cyc %0d got %b/%h/%b want 001/2a/0100", i, rsp_valid, rsp_data, rsp_flags); end
      n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL bp_ready cyc %0d got %b want 000", i, req_ready); end
      n_checks++; if ((bus_oe & ~noe) !== 1'b0) begin n_fail++; $display("FAIL contention cyc %0d got oe=%b noe=%b want no overlap", i, bus_oe, noe); end
      step();
    end
    rsp_ready = 3'b111;
    step();
    n_checks++; if ({rsp_valid, req_ready} !== {3'b000, 3'b010}) begin n_fail++; $display("FAIL bp_release got %b/%b want 000/010", rsp_valid, req_ready); end
    req_valid = '0;
    step();
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [7:0] d; logic [3:0] f; logic [N-1:0] rv;
    run_txn(0, 8'h11, 8'h22, 2'b00, 1'b0, lat, d, f, rv);
    set_req(0, 8'h05, 8'h06, 2'b00, 1'b0);
    set_req(1, 8'h07, 8'h08, 2'b00, 1'b0);
    req_valid = 3'b011;
    #1;
    n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL mid_grant got %b want 010", req_ready); end
    step();
    step();
    n_checks++; if ({noe, ynwe} !== 2'b01) begin n_fail++; $display("FAIL mid_in_read got noe/ynwe %b want 01", {noe, ynwe}); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_checks++; if ({noe, ynwe, bus_oe, rsp_valid} !== 6'b110000) begin n_fail++; $display("FAIL mid_reset_ctrl got %b want 110000", {noe, ynwe, bus_oe, rsp_valid}); end
    n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL mid_regrant got %b want 001", req_ready); end
    req_valid = '0;
    step();
    step();
    n_checks++; if (rsp_valid !== 3'b000) begin n_fail++; $display("FAIL mid_no_rsp got %b want 000", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_round_robin();
    test_shift_sub();
    test_backpressure();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
